// File: rtl/cipo_pkg.sv
// Shared sizing and types for recovering the A/B word pair from an
// oversampled CIPO capture buffer.
package cipo_pkg;
  localparam int WORD_BITS  = 16;
  localparam int OVERSAMPLE = 4;
  localparam int BUF_BITS   = 74;
  localparam int MAX_PHASE  = 11;

  typedef logic [WORD_BITS-1:0] cipo_word_t;

  typedef struct packed {
    cipo_word_t b;
    cipo_word_t a;
  } cipo_pair_t;

  // Phases beyond MAX_PHASE would walk the falling-edge sample off the buffer.
  function automatic logic [3:0] clamp_phase(input logic [3:0] ps);
    return (ps > 4'(MAX_PHASE)) ? 4'(MAX_PHASE) : ps;
  endfunction
endpackage

// File: rtl/cipo_word_extract.sv
// Strided gather of one 16-bit word out of the oversample buffer, MSB first.
// EDGE_OFFSET selects rising (0) or falling (2) sample within each SCLK bit.
module cipo_word_extract
  import cipo_pkg::*;
#(
  parameter int EDGE_OFFSET = 0
) (
  input  logic [3:0]          phase_i,
  input  logic [BUF_BITS-1:0] buf_i,
  output cipo_word_t          word_o
);
  for (genvar k = 0; k < WORD_BITS; k++) begin : g_bit
    logic [6:0] idx;
    assign idx = 7'(phase_i) + 7'(OVERSAMPLE * k + EDGE_OFFSET);
    assign word_o[WORD_BITS-1-k] = buf_i[idx];
  end
endmodule

// File: rtl/cipo_combined_phase_selector.sv
// Phase-compensated DDR word recovery: combinational gather, one output register.
module cipo_combined_phase_selector
  import cipo_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [3:0]              phase_select,
  input  logic [BUF_BITS-1:0]     CIPO4x,
  output logic [2*WORD_BITS-1:0]  CIPO,
  output logic                    phase_clamped
);
  logic [3:0] phase_eff;
  cipo_pair_t pair_d, pair_q;
  logic       clamped_d, clamped_q;

  assign phase_eff = clamp_phase(phase_select);
  assign clamped_d = (phase_select > 4'(MAX_PHASE));

  cipo_word_extract #(.EDGE_OFFSET(0)) u_word_a (
    .phase_i (phase_eff),
    .buf_i   (CIPO4x),
    .word_o  (pair_d.a)
  );

  cipo_word_extract #(.EDGE_OFFSET(2)) u_word_b (
    .phase_i (phase_eff),
    .buf_i   (CIPO4x),
    .word_o  (pair_d.b)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pair_q    <= '0;
      clamped_q <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      clamped_q <= clamped_d;
    end
  end

  assign CIPO          = pair_q;
  assign phase_clamped = clamped_q;
endmodule

// File: tb/tb_cipo_combined_phase_selector.sv
// Directed vector table, reset/latency sequences and a random phase sweep
// against a bit-level reference model.
module tb_cipo_combined_phase_selector;
  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  phase_select;
  logic [73:0] CIPO4x;
  logic [31:0] CIPO;
  logic        phase_clamped;

  int checks = 0;
  int failures = 0;

  cipo_combined_phase_selector dut (
    .clk           (clk),
    .rstn          (rstn),
    .phase_select  (phase_select),
    .CIPO4x        (CIPO4x),
    .CIPO          (CIPO),
    .phase_clamped (phase_clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ph;
    logic [73:0] bf;
    logic [31:0] exp_cipo;
    logic        exp_clamp;
  } vec_t;

  vec_t vecs[$];

  // Reference: A[15-k] = buf[p+4k], B[15-k] = buf[p+4k+2], p clamped to 11.
  function automatic logic [31:0] model(input int ph, input logic [73:0] bf);
    logic [15:0] a, b;
    int p;
    p = (ph > 11) ? 11 : ph;
    for (int k = 0; k < 16; k++) begin
      a[15-k] = bf[p + 4*k];
      b[15-k] = bf[p + 4*k + 2];
    end
    return {b, a};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Drive away from the active edge, let one edge register, sample after it.
  task automatic step(input logic [3:0] ph, input logic [73:0] bf);
    @(negedge clk);
    phase_select = ph;
    CIPO4x       = bf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [73:0] one;
    logic [73:0] pat;
    logic [95:0] rnd;
    logic [73:0] bx, by;

    one = 74'd1;
    pat = '0;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) pat[4*k] = 1'b1;
      else            pat[4*k+2] = 1'b1;
    end

    vecs.push_back('{"bit0_p0",   4'd0,  one << 0,  32'h0000_8000, 1'b0});
    vecs.push_back('{"bit2_p0",   4'd0,  one << 2,  32'h8000_0000, 1'b0});
    vecs.push_back('{"bit1_p0",   4'd0,  one << 1,  32'h0000_0000, 1'b0});
    vecs.push_back('{"bit2_p2",   4'd2,  one << 2,  32'h0000_8000, 1'b0});
    vecs.push_back('{"bit71_p11", 4'd11, one << 71, 32'h0000_0001, 1'b0});
    vecs.push_back('{"bit73_p11", 4'd11, one << 73, 32'h0001_0000, 1'b0});
    vecs.push_back('{"clamp_p15", 4'd15, one << 11, 32'h0000_8000, 1'b1});
    vecs.push_back('{"clamp_p12", 4'd12, one << 11, 32'h0000_8000, 1'b1});
    vecs.push_back('{"pattern",   4'd0,  pat,       32'h5555_AAAA, 1'b0});

    // Reset with all-ones input must still hold zero.
    rstn = 1'b0;
    phase_select = 4'd0;
    CIPO4x = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk32("reset_cipo", CIPO, 32'h0);
    chk1("reset_clamp", phase_clamped, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk32("post_reset_ones", CIPO, 32'hFFFF_FFFF);

    foreach (vecs[i]) begin
      step(vecs[i].ph, vecs[i].bf);
      chk32({vecs[i].name, "_cipo"}, CIPO, vecs[i].exp_cipo);
      chk1({vecs[i].name, "_clamp"}, phase_clamped, vecs[i].exp_clamp);
    end

    // Latency: a buffer change between edges shows up exactly one edge later.
    rnd = {$urandom, $urandom, $urandom}; bx = rnd[73:0];
    rnd = {$urandom, $urandom, $urandom}; by = rnd[73:0] ^ 74'h1;
    step(4'd5, bx);
    chk32("lat_first", CIPO, model(5, bx));
    @(negedge clk);
    CIPO4x = by;
    #2;
    chk32("lat_hold", CIPO, model(5, bx));
    @(posedge clk); #1;
    chk32("lat_update", CIPO, model(5, by));

    // Mid-operation reset zeroes outputs regardless of inputs.
    step(4'd14, '1);
    chk1("pre_rst_clamp", phase_clamped, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk32("mid_rst_cipo", CIPO, 32'h0);
    chk1("mid_rst_clamp", phase_clamped, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Random sweep over every phase value.
    for (int p = 0; p < 16; p++) begin
      for (int r = 0; r < 4; r++) begin
        rnd = {$urandom, $urandom, $urandom};
        step(4'(p), rnd[73:0]);
        chk32($sformatf("rand_p%0d_cipo", p), CIPO, model(p, rnd[73:0]));
        chk1($sformatf("rand_p%0d_clamp", p), phase_clamped, p > 11);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
